// File: rtl/tile_scanline_renderer.sv
// rtl/tile_scanline_renderer.sv - tile-map background scanline renderer with ready/valid pixel output
// Walks one scrolled scanline tile by tile: map read, tile-row read, then shift pixels out through the palette.
module tile_scanline_renderer #(
  parameter int LINE_WIDTH = 160,
  parameter int TILE_SIZE  = 8,
  parameter int BPP        = 2,
  parameter int SHADE_W    = 2,
  parameter int MAP_W      = 32,
  parameter int MAP_H      = 32,
  parameter int TILE_COUNT = 256
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    drawline,
  input  logic [7:0]                              ly,
  input  logic [7:0]                              scx,
  input  logic [7:0]                              scy,
  input  logic [(2**BPP)*SHADE_W-1:0]             palette,
  output logic [$clog2(MAP_W*MAP_H)-1:0]          map_addr,
  input  logic [$clog2(TILE_COUNT)-1:0]           map_rdata,
  output logic [$clog2(TILE_COUNT*TILE_SIZE)-1:0] tile_addr,
  input  logic [TILE_SIZE*BPP-1:0]                tile_rdata,
  output logic                                    px_valid,
  input  logic                                    px_ready,
  output logic [$clog2(LINE_WIDTH)-1:0]           px_x,
  output logic [SHADE_W-1:0]                      px_shade,
  output logic                                    busy,
  output logic                                    renderComplete
);

  localparam int TS_W  = $clog2(TILE_SIZE);
  localparam int X_W   = $clog2(MAP_W*TILE_SIZE);
  localparam int Y_W   = $clog2(MAP_H*TILE_SIZE);
  localparam int MA_W  = $clog2(MAP_W*MAP_H);
  localparam int PX_W  = $clog2(LINE_WIDTH);
  localparam int PAL_W = (2**BPP)*SHADE_W;
  localparam int ROW_W = TILE_SIZE*BPP;

  typedef enum logic [2:0] {
    IDLE,
    MAP_RD,
    TILE_RD,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q;
  logic               drawline_q;
  logic [Y_W-1:0]     y_q;
  logic [X_W-1:0]     mx_q;
  logic [PAL_W-1:0]   palette_q;
  logic [ROW_W-1:0]   shifter_q;
  logic               loaded_q;
  logic [PX_W-1:0]    px_x_q;
  logic               px_valid_q;
  logic [SHADE_W-1:0] px_shade_q;
  logic               busy_q;
  logic               done_q;
  logic [MA_W-1:0]    map_addr_q;

  logic [Y_W-1:0]     y_start;
  logic [X_W-1:0]     x_start;
  logic [X_W-1:0]     mx_d;
  logic [ROW_W-1:0]   load_row;
  logic [ROW_W-1:0]   shift_row;
  logic [BPP-1:0]     load_idx;
  logic [BPP-1:0]     shift_idx;
  logic               start;
  logic               last_px;
  logic               tile_end;

  // Map dimensions are powers of two, so truncation implements the wrap-around.
  assign y_start   = Y_W'(16'(ly) + 16'(scy));
  assign x_start   = X_W'(16'(scx));
  assign mx_d      = mx_q + X_W'(1);
  assign start     = drawline && !drawline_q;
  assign last_px   = (px_x_q == PX_W'(LINE_WIDTH - 1));
  assign tile_end  = &mx_q[TS_W-1:0];

  // The fine-scroll skip happens at load time: leading pixels are shifted out before they are seen.
  assign load_row  = tile_rdata << (mx_q[TS_W-1:0] * BPP);
  assign shift_row = shifter_q << BPP;
  assign load_idx  = load_row[ROW_W-1 -: BPP];
  assign shift_idx = shift_row[ROW_W-1 -: BPP];

  assign map_addr       = map_addr_q;
  assign tile_addr      = (state_q == TILE_RD) ? {map_rdata, y_q[TS_W-1:0]} : '0;
  assign px_valid       = px_valid_q;
  assign px_x           = px_x_q;
  assign px_shade       = px_shade_q;
  assign busy           = busy_q;
  assign renderComplete = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drawline_q <= 1'b0;
      y_q        <= '0;
      mx_q       <= '0;
      palette_q  <= '0;
      shifter_q  <= '0;
      loaded_q   <= 1'b0;
      px_x_q     <= '0;
      px_valid_q <= 1'b0;
      px_shade_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      map_addr_q <= '0;
    end else begin
      drawline_q <= drawline;
      case (state_q)
        IDLE: begin
          if (start) begin
            y_q        <= y_start;
            mx_q       <= x_start;
            palette_q  <= palette;
            px_x_q     <= '0;
            busy_q     <= 1'b1;
            map_addr_q <= {y_start[Y_W-1:TS_W], x_start[X_W-1:TS_W]};
            state_q    <= MAP_RD;
          end
        end
        MAP_RD: begin
          state_q <= TILE_RD;
        end
        TILE_RD: begin
          loaded_q <= 1'b0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          if (!loaded_q) begin
            shifter_q  <= load_row;
            px_shade_q <= palette_q[load_idx*SHADE_W +: SHADE_W];
            px_valid_q <= 1'b1;
            loaded_q   <= 1'b1;
          end else if (px_ready) begin
            if (last_px) begin
              px_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              px_x_q <= px_x_q + PX_W'(1);
              mx_q   <= mx_d;
              if (tile_end) begin
                px_valid_q <= 1'b0;
                map_addr_q <= {y_q[Y_W-1:TS_W], mx_d[X_W-1:TS_W]};
                state_q    <= MAP_RD;
              end else begin
                shifter_q  <= shift_row;
                px_shade_q <= palette_q[shift_idx*SHADE_W +: SHADE_W];
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scanline_renderer.sv
// tb/tb_tile_scanline_renderer.sv - scoreboard bench for tile_scanline_renderer (8x8/2bpp and 16x16/4bpp)
module tb_tile_scanline_renderer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, drawline, drawline_b, px_ready;
  logic [7:0]  ly, scx, scy, palette;
  logic [31:0] palette_b;
  logic [9:0]  map_addr, map_addr_b;
  logic [7:0]  map_rdata, map_rdata_b;
  logic [10:0] tile_addr;
  logic [15:0] tile_rdata;
  logic [11:0] tile_addr_b;
  logic [63:0] tile_rdata_b;
  logic        px_valid, px_valid_b, busy, busy_b, rc, rc_b;
  logic [7:0]  px_x, px_x_b;
  logic [1:0]  px_shade, px_shade_b;

  logic [7:0]  map_a  [1024];
  logic [15:0] tile_a [2048];
  logic [7:0]  map_b  [1024];
  logic [63:0] tile_b [4096];

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_b[$];
  int done_cnt = 0;
  int done_b = 0;
  bit rand_ready = 0;
  bit hold_pending = 0;
  int hold_x, hold_s;

  tile_scanline_renderer dut (
    .clk(clk), .rst_n(rst_n), .drawline(drawline), .ly(ly), .scx(scx), .scy(scy),
    .palette(palette), .map_addr(map_addr), .map_rdata(map_rdata), .tile_addr(tile_addr),
    .tile_rdata(tile_rdata), .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x),
    .px_shade(px_shade), .busy(busy), .renderComplete(rc)
  );

  tile_scanline_renderer #(.TILE_SIZE(16), .BPP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .drawline(drawline_b), .ly(ly), .scx(scx), .scy(scy),
    .palette(palette_b), .map_addr(map_addr_b), .map_rdata(map_rdata_b), .tile_addr(tile_addr_b),
    .tile_rdata(tile_rdata_b), .px_valid(px_valid_b), .px_ready(px_ready), .px_x(px_x_b),
    .px_shade(px_shade_b), .busy(busy_b), .renderComplete(rc_b)
  );

  always @(posedge clk) begin
    map_rdata    <= map_a[map_addr];
    tile_rdata   <= tile_a[tile_addr];
    map_rdata_b  <= map_b[map_addr_b];
    tile_rdata_b <= tile_b[tile_addr_b];
  end

  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Reference: pixel x of a line is the scrolled map position, looked up tile by tile.
  function automatic int ref_a(input int x, input int l, input int sx, input int sy, input int pal);
    int y, xm, tile, row, pix, idx;
    y    = (l + sy) % 256;
    xm   = (sx + x) % 256;
    tile = map_a[(y / 8) * 32 + xm / 8];
    row  = tile_a[tile * 8 + y % 8];
    pix  = xm % 8;
    idx  = (row >> (2 * (7 - pix))) & 3;
    return (pal >> (2 * idx)) & 3;
  endfunction

  function automatic int ref_b(input int x, input int sx, input logic [31:0] pal);
    int xm, tile, pix, idx;
    logic [63:0] row;
    xm   = (sx + x) % 512;
    tile = map_b[xm / 16];
    row  = tile_b[tile * 16];
    pix  = xm % 16;
    idx  = int'((row >> (4 * (15 - pix))) & 64'hF);
    return int'((pal >> (2 * idx)) & 32'h3);
  endfunction

  task automatic chk_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 0;
      end else begin
        if (rc)   done_cnt++;
        if (rc_b) done_b++;
        if (hold_pending) begin
          chk_eq("hold_valid", int'(px_valid), 1);
          chk_eq("hold_x", int'(px_x), hold_x);
          chk_eq("hold_shade", int'(px_shade), hold_s);
        end
        hold_pending = px_valid && !px_ready;
        hold_x = px_x;
        hold_s = px_shade;
        if (px_valid && px_ready) begin
          if (exp_q.size() == 0) chk_eq("pix_a_unexpected_x", int'(px_x), -1);
          else begin
            e = exp_q.pop_front();
            chk_eq("pix_a_x", int'(px_x), e >> 8);
            chk_eq("pix_a_shade", int'(px_shade), e & 255);
          end
        end
        if (px_valid_b && px_ready) begin
          if (exp_b.size() == 0) chk_eq("pix_b_unexpected_x", int'(px_x_b), -1);
          else begin
            e = exp_b.pop_front();
            chk_eq("pix_b_x", int'(px_x_b), e >> 8);
            chk_eq("pix_b_shade", int'(px_shade_b), e & 255);
          end
        end
      end
    end
  endtask

  task automatic start_line(input string name, input int l, input int sx, input int sy, input int pal);
    done_cnt = 0;
    for (int x = 0; x < 160; x++) exp_q.push_back((x << 8) | ref_a(x, l, sx, sy, pal));
    @(posedge clk); #1;
    ly = 8'(l); scx = 8'(sx); scy = 8'(sy); palette = 8'(pal); drawline = 1'b1;
    @(posedge clk); #1;
    chk_eq({name, "_busy_start"}, int'(busy), 1);
    ly = 8'($urandom); scx = 8'($urandom); scy = 8'($urandom); palette = 8'($urandom);
    @(posedge clk); #1;
    drawline = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk_eq({name, "_done_pulses"}, done_cnt, 1);
    chk_eq({name, "_pixels_left"}, exp_q.size(), 0);
    chk_eq({name, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic run_line(input string name, input int l, input int sx, input int sy, input int pal);
    start_line(name, l, sx, sy, pal);
    wait_done(name);
  endtask

  task automatic randomize_a();
    foreach (map_a[i])  map_a[i]  = 8'($urandom);
    foreach (tile_a[i]) tile_a[i] = 16'($urandom);
  endtask

  task automatic run_b(input string name, input int sx, input logic [31:0] pb);
    int n;
    done_b = 0;
    for (int x = 0; x < 160; x++) exp_b.push_back((x << 8) | ref_b(x, sx, pb));
    @(posedge clk); #1;
    ly = 8'd0; scy = 8'd0; scx = 8'(sx); palette_b = pb; drawline_b = 1'b1;
    @(posedge clk); #1;
    chk_eq({name, "_busy_start"}, int'(busy_b), 1);
    drawline_b = 1'b0;
    n = 0;
    while (done_b == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk_eq({name, "_done_pulses"}, done_b, 1);
    chk_eq({name, "_pixels_left"}, exp_b.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; drawline = 1'b0; drawline_b = 1'b0;
    ly = '0; scx = '0; scy = '0; palette = '0; palette_b = '0;
    randomize_a();
    foreach (map_a[i])  map_a[i]  = 8'd0;
    tile_a[0] = 16'hCCCC;
    foreach (map_b[i])  map_b[i]  = 8'd0;
    foreach (tile_b[i]) tile_b[i] = {$urandom, $urandom};
    tile_b[0] = 64'hF0F0_F0F0_F0F0_F0F0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk_eq("rst_px_valid", int'(px_valid), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_complete", int'(rc), 0);
    chk_eq("rst_px_x", int'(px_x), 0);
    chk_eq("rst_px_shade", int'(px_shade), 0);
    chk_eq("rst_map_addr", int'(map_addr), 0);
    chk_eq("rst_tile_addr", int'(tile_addr), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_line("checker", 0, 0, 0, 8'hE4);
    run_line("fine_scx3", 0, 3, 0, 8'hE4);
    run_line("inverted_pal", 0, 0, 0, 8'h1B);
    randomize_a();
    run_line("wrap_scx250", 0, 250, 0, 8'hE4);
    run_line("scy6_ly2", 2, 0, 6, 8'hE4);
    run_line("ly255_scy1", 255, 17, 1, 8'h9C);
    rand_ready = 1;
    run_line("stall_scx250", 0, 250, 0, 8'hE4);
    run_line("stall_scy6", 2, 5, 6, 8'h1B);

    start_line("busy_edge", 40, 100, 9, 8'hD2);
    repeat (40) @(posedge clk);
    #1 drawline = 1'b1;
    repeat (10) @(posedge clk);
    #1 drawline = 1'b0;
    wait_done("busy_edge");

    start_line("midreset", 77, 12, 200, 8'h6C);
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_eq("midreset_px_valid", int'(px_valid), 0);
    chk_eq("midreset_busy", int'(busy), 0);
    chk_eq("midreset_complete", int'(rc), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_eq("midreset_no_pulse", done_cnt, 0);
    run_line("after_reset", 77, 12, 200, 8'h6C);

    for (int i = 0; i < 5; i++) begin
      randomize_a();
      rand_ready = i[0];
      run_line($sformatf("rand%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    rand_ready = 0;
    run_b("b_checker", 0, $urandom);
    foreach (map_b[i]) map_b[i] = 8'($urandom);
    rand_ready = 1;
    run_b("b_scroll", 21, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
